decode_stage: RTL and testbench

Registered, parametrised instruction-decode pipeline stage. Classifies a 32-bit RISC-V RV32I instruction by opcode internally, with no per-format enables from control. Extracts register indices, function fields and a sign-extended immediate, and computes operand B, the load/store address and the branch/jump target. Sits between fetch/register-file read and execute, with valid/ready handshakes on both sides.

---
 rtl/decode_stage.sv | 240 ++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ============================================================================
// decode_stage : registered RV32I decode stage with valid/ready handshakes.
// Optional two-entry skid buffer is enabled by defining DECODE_SKID_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] R1_i,
    input  logic [XLEN-1:0] R2_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [4:0]      RS1_o,
    output logic [4:0]      RS2_o,
    output logic [4:0]      RD_o,
    output logic [6:0]      opcode_o,
    output logic [2:0]      func3_o,
    output logic [6:0]      func7_o,
    output logic [2:0]      fmt_o,
    output logic            illegal_o,
    output logic [XLEN-1:0] immed_o,
    output logic [XLEN-1:0] operand_B_o,
    output logic [XLEN-1:0] address_o,
    output logic [XLEN-1:0] target_o
);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_SB  = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_UJ  = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [2:0]      fmt;
        logic            illegal;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [XLEN-1:0] immed;
        logic [XLEN-1:0] opb;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] target;
    } dec_t;

    logic [6:0]      w_op;
    logic [2:0]      w_fmt;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_immed;
    logic [XLEN-1:0] w_sum_r1;
    logic [XLEN-1:0] w_sum_pc;
    dec_t            w_dec;
    dec_t            w_out;
    logic            w_ready;
    logic            w_valid;

    assign w_op = instr_i[6:0];

    always_comb begin
        w_fmt = FMT_ILL;
        case (w_op)
            OP_REG:                               w_fmt = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:  w_fmt = FMT_I;
            OP_STORE:                             w_fmt = FMT_S;
            OP_BRANCH:                            w_fmt = FMT_SB;
            OP_LUI, OP_AUIPC:                     w_fmt = FMT_U;
            OP_JAL:                               w_fmt = FMT_UJ;
            default:                              w_fmt = FMT_ILL;
        endcase
    end

    // Immediates are assembled at 32 bits, then sign-extended to XLEN.
    always_comb begin
        w_imm32 = 32'd0;
        case (w_fmt)
            FMT_I:   w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            FMT_S:   w_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            FMT_SB:  w_imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                instr_i[30:25], instr_i[11:8], 1'b0};
            FMT_U:   w_imm32 = {instr_i[31:12], 12'd0};
            FMT_UJ:  w_imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                instr_i[20], instr_i[30:21], 1'b0};
            default: w_imm32 = 32'd0;
        endcase
    end

    assign w_immed  = XLEN'($signed(w_imm32));
    assign w_sum_r1 = R1_i + w_immed;
    assign w_sum_pc = pc_i + w_immed;

    always_comb begin
        w_dec         = '0;
        w_dec.fmt     = w_fmt;
        w_dec.illegal = (w_fmt == FMT_ILL);
        if (w_fmt != FMT_ILL) begin
            w_dec.opcode = w_op;
            w_dec.immed  = w_immed;
            w_dec.opb    = w_immed;
        end
        if (w_fmt == FMT_R || w_fmt == FMT_I || w_fmt == FMT_U || w_fmt == FMT_UJ)
            w_dec.rd = instr_i[11:7];
        if (w_fmt == FMT_R || w_fmt == FMT_I || w_fmt == FMT_S || w_fmt == FMT_SB) begin
            w_dec.rs1   = instr_i[19:15];
            w_dec.func3 = instr_i[14:12];
        end
        if (w_fmt == FMT_R || w_fmt == FMT_S || w_fmt == FMT_SB)
            w_dec.rs2 = instr_i[24:20];
        if (w_fmt == FMT_R || w_fmt == FMT_I)
            w_dec.func7 = instr_i[31:25];
        if (w_fmt == FMT_R || w_fmt == FMT_SB)
            w_dec.opb = R2_i;
        if (w_op == OP_LOAD || w_op == OP_STORE)
            w_dec.addr = w_sum_r1;
        if (w_fmt == FMT_SB || w_fmt == FMT_UJ)
            w_dec.target = w_sum_pc;
        else if (w_op == OP_JALR)
            w_dec.target = {w_sum_r1[XLEN-1:1], 1'b0};
    end

`ifdef DECODE_SKID_EN
    // Entry 0 is always the head presented downstream; entry 1 is the skid slot.
    dec_t       r_e0;
    dec_t       r_e1;
    logic [1:0] r_cnt;
    logic       r_ready;
    logic       w_push;
    logic       w_pop;
    logic [1:0] w_cnt_nxt;

    assign w_push = valid_i && r_ready;
    assign w_pop  = (r_cnt != 2'd0) && ready_i;

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + 2'd1;
            2'b01:   w_cnt_nxt = r_cnt - 2'd1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_e0    <= '0;
            r_e1    <= '0;
            r_cnt   <= 2'd0;
            r_ready <= 1'b1;
        end else if (flush_i) begin
            r_cnt   <= 2'd0;
            r_ready <= 1'b1;
        end else begin
            case (r_cnt)
                2'd0: begin
                    if (w_push)
                        r_e0 <= w_dec;
                end
                2'd1: begin
                    if (w_push && w_pop)
                        r_e0 <= w_dec;
                    else if (w_push)
                        r_e1 <= w_dec;
                end
                default: begin
                    if (w_pop)
                        r_e0 <= r_e1;
                end
            endcase
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_cnt_nxt != 2'd2);
        end
    end

    assign w_ready = r_ready;
    assign w_valid = (r_cnt != 2'd0);
    assign w_out   = r_e0;
`else
    dec_t r_data;
    logic r_valid;

    assign w_ready = !r_valid || ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_ready) begin
            r_valid <= valid_i;
            if (valid_i)
                r_data <= w_dec;
        end
    end

    assign w_valid = r_valid;
    assign w_out   = r_data;
`endif

    assign ready_o     = w_ready;
    assign valid_o     = w_valid;
    assign fmt_o       = w_out.fmt;
    assign illegal_o   = w_out.illegal;
    assign RS1_o       = w_out.rs1;
    assign RS2_o       = w_out.rs2;
    assign RD_o        = w_out.rd;
    assign opcode_o    = w_out.opcode;
    assign func3_o     = w_out.func3;
    assign func7_o     = w_out.func7;
    assign immed_o     = w_out.immed;
    assign operand_B_o = w_out.opb;
    assign address_o   = w_out.addr;
    assign target_o    = w_out.target;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// tb_decode_stage : scoreboard bench for decode_stage with directed vectors.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_decode_stage;

    typedef struct {
        logic [2:0]  fmt;
        logic        ill;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] opb;
        logic [31:0] addr;
        logic [31:0] tgt;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] r1;
        logic [31:0] r2;
        exp_t        e;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic [31:0] R1_i;
    logic [31:0] R2_i;
    logic        flush_i;
    logic        valid_o;
    logic        ready_i;
    logic [4:0]  RS1_o;
    logic [4:0]  RS2_o;
    logic [4:0]  RD_o;
    logic [6:0]  opcode_o;
    logic [2:0]  func3_o;
    logic [6:0]  func7_o;
    logic [2:0]  fmt_o;
    logic        illegal_o;
    logic [31:0] immed_o;
    logic [31:0] operand_B_o;
    logic [31:0] address_o;
    logic [31:0] target_o;

    int   checks = 0;
    int   errors = 0;
    bit   run_mon = 1'b0;
    exp_t q[$];
    exp_t cur_exp;
    vec_t vecs[9];

    decode_stage #(.XLEN(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .instr_i(instr_i), .pc_i(pc_i), .R1_i(R1_i), .R2_i(R2_i),
        .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
        .RS1_o(RS1_o), .RS2_o(RS2_o), .RD_o(RD_o), .opcode_o(opcode_o),
        .func3_o(func3_o), .func7_o(func7_o), .fmt_o(fmt_o), .illegal_o(illegal_o),
        .immed_o(immed_o), .operand_B_o(operand_B_o), .address_o(address_o),
        .target_o(target_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mkv(
        input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] r1,
        input logic [31:0] r2, input logic [2:0] fmt, input logic ill,
        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
        input logic [31:0] imm, input logic [31:0] opb, input logic [31:0] addr,
        input logic [31:0] tgt);
        vec_t v;
        v.instr = instr; v.pc = pc; v.r1 = r1; v.r2 = r2;
        v.e.fmt = fmt; v.e.ill = ill; v.e.rd = rd; v.e.rs1 = rs1; v.e.rs2 = rs2;
        v.e.op = op; v.e.f3 = f3; v.e.f7 = f7; v.e.imm = imm; v.e.opb = opb;
        v.e.addr = addr; v.e.tgt = tgt;
        return v;
    endfunction

    // Monitor and scoreboard: sampled on the falling edge, between active edges.
    always @(negedge clk_i) begin
        if (rst_ni && run_mon) begin
            logic exp_rdy;
            exp_t e;
`ifdef DECODE_SKID_EN
            exp_rdy = (q.size() < 2);
`else
            exp_rdy = (q.size() == 0) || ready_i;
`endif
            chk("ready_o", {63'd0, ready_o}, {63'd0, exp_rdy});
            chk("valid_o", {63'd0, valid_o}, {63'd0, q.size() != 0});
            if (valid_o && q.size() != 0) begin
                e = q[0];
                chk("fmt_o",       {61'd0, fmt_o},       {61'd0, e.fmt});
                chk("illegal_o",   {63'd0, illegal_o},   {63'd0, e.ill});
                chk("RD_o",        {59'd0, RD_o},        {59'd0, e.rd});
                chk("RS1_o",       {59'd0, RS1_o},       {59'd0, e.rs1});
                chk("RS2_o",       {59'd0, RS2_o},       {59'd0, e.rs2});
                chk("opcode_o",    {57'd0, opcode_o},    {57'd0, e.op});
                chk("func3_o",     {61'd0, func3_o},     {61'd0, e.f3});
                chk("func7_o",     {57'd0, func7_o},     {57'd0, e.f7});
                chk("immed_o",     {32'd0, immed_o},     {32'd0, e.imm});
                chk("operand_B_o", {32'd0, operand_B_o}, {32'd0, e.opb});
                chk("address_o",   {32'd0, address_o},   {32'd0, e.addr});
                chk("target_o",    {32'd0, target_o},    {32'd0, e.tgt});
                if (ready_i && !flush_i)
                    void'(q.pop_front());
            end
            if (valid_i && ready_o && !flush_i)
                q.push_back(cur_exp);
            if (flush_i)
                q.delete();
        end
    end

    task automatic drive(input int i);
        instr_i = vecs[i].instr;
        pc_i    = vecs[i].pc;
        R1_i    = vecs[i].r1;
        R2_i    = vecs[i].r2;
        cur_exp = vecs[i].e;
        valid_i = 1'b1;
    endtask

    task automatic send(input int i);
        bit acc = 1'b0;
        drive(i);
        for (int n = 0; n < 30; n++) begin
            @(negedge clk_i);
            if (ready_o) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        chk("accept", {63'd0, acc}, 64'd1);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        vecs[0] = mkv(32'hFFF10093, 32'h0,   32'h5,    32'h33, 3'd1, 1'b0, 5'd1, 5'd2, 5'd0,
                      7'h13, 3'd0, 7'h7F, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0);
        vecs[1] = mkv(32'hFE208CE3, 32'h100, 32'h3,    32'h7,  3'd3, 1'b0, 5'd0, 5'd1, 5'd2,
                      7'h63, 3'd0, 7'h00, 32'hFFFFFFF8, 32'h7, 32'h0, 32'hF8);
        vecs[2] = mkv(32'h00532623, 32'h200, 32'h1000, 32'h55, 3'd2, 1'b0, 5'd0, 5'd6, 5'd5,
                      7'h23, 3'd2, 7'h00, 32'hC, 32'hC, 32'h100C, 32'h0);
        vecs[3] = mkv(32'h001000EF, 32'h100, 32'h0,    32'h0,  3'd5, 1'b0, 5'd1, 5'd0, 5'd0,
                      7'h6F, 3'd0, 7'h00, 32'h800, 32'h800, 32'h0, 32'h900);
        vecs[4] = mkv(32'h0000007F, 32'h300, 32'h11,   32'h22, 3'd7, 1'b1, 5'd0, 5'd0, 5'd0,
                      7'h00, 3'd0, 7'h00, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[5] = mkv(32'h002081B3, 32'h0,   32'hA,    32'h14, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2,
                      7'h33, 3'd0, 7'h00, 32'h0, 32'h14, 32'h0, 32'h0);
        vecs[6] = mkv(32'hFFC32283, 32'h0,   32'h2000, 32'h0,  3'd1, 1'b0, 5'd5, 5'd6, 5'd0,
                      7'h03, 3'd2, 7'h7F, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h1FFC, 32'h0);
        vecs[7] = mkv(32'h005100E7, 32'h40,  32'h1000, 32'h0,  3'd1, 1'b0, 5'd1, 5'd2, 5'd0,
                      7'h67, 3'd0, 7'h00, 32'h5, 32'h5, 32'h0, 32'h1004);
        vecs[8] = mkv(32'h123453B7, 32'h0,   32'h99,   32'h88, 3'd4, 1'b0, 5'd7, 5'd0, 5'd0,
                      7'h37, 3'd0, 7'h00, 32'h12345000, 32'h12345000, 32'h0, 32'h0);

        rst_ni = 1'b0; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
        instr_i = '0; pc_i = '0; R1_i = '0; R2_i = '0;
        cur_exp = vecs[4].e;
        #12;
        chk("reset valid_o",   {63'd0, valid_o},   64'd0);
        chk("reset fmt_o",     {61'd0, fmt_o},     64'd0);
        chk("reset illegal_o", {63'd0, illegal_o}, 64'd0);
        chk("reset immed_o",   {32'd0, immed_o},   64'd0);
        chk("reset target_o",  {32'd0, target_o},  64'd0);
        step();
        rst_ni = 1'b1;
        #1;
        chk("ready after reset", {63'd0, ready_o}, 64'd1);
        run_mon = 1'b1;

        // Single instructions of every format, including an illegal opcode.
        for (int i = 0; i < 9; i++)
            send(i);
        repeat (3) step();
        chk("drain singles", 64'(q.size()), 64'd0);

        // Six-instruction stream with three cycles of downstream backpressure.
        fork
            begin
                send(5); send(6); send(7); send(8); send(0); send(1);
            end
            begin
                repeat (3) step();
                ready_i = 1'b0;
                repeat (3) step();
                ready_i = 1'b1;
            end
        join
        repeat (4) step();
        chk("drain stream", 64'(q.size()), 64'd0);

        // Flush while stalled, with a new instruction offered in the flush cycle.
        ready_i = 1'b0;
        drive(2);
        step();
        drive(3);
        step();
        drive(0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        chk("valid_o after flush", {63'd0, valid_o}, 64'd0);
        ready_i = 1'b1;
        repeat (4) step();

        // Asynchronous reset with an instruction held.
        ready_i = 1'b0;
        drive(1);
        step();
        valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        q.delete();
        chk("mid reset valid_o", {63'd0, valid_o}, 64'd0);
        chk("mid reset immed_o", {32'd0, immed_o}, 64'd0);
        step();
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        #1;
        chk("ready after mid reset", {63'd0, ready_o}, 64'd1);
        send(3);
        repeat (3) step();
        chk("drain final", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
